id_ex_shift_stage: RTL and testbench
====================================

ID_EX_SHIFT_STAGE -- requirements
Module: id_ex_shift_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed (XLEN 32, register index 5).
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  stage can accept
- instr  in  32  raw RV32I instruction
- rs1_data  in  32  register-file read, rs1
- rs2_data  in  32  register-file read, rs2
- stall  in  1  downstream hold request
- flush  in  1  kill captured/incoming instruction
- exmem_we, exmem_rd, exmem_data  in  1/5/32  EX/MEM forward source
- memwb_we, memwb_rd, memwb_data  in  1/5/32  MEM/WB forward source
- out_valid  out  1  registered instruction valid
- shiftSel  out  2  00 none, 01 SLL, 10 SRL, 11 SRA
- alu_a  out  32  shift operand
- alu_b  out  32  shift amount source; the consumer uses bits [4:0]
- rd_out  out  5  destination register
- illegal  out  1  malformed shift encoding

Function
REQ-003 SHALL decode opcode 0110011: funct3 001/funct7 0000000 -> SLL; funct3 101/funct7 0000000 -> SRL; funct3 101/funct7 0100000 -> SRA.
REQ-004 SHALL decode opcode 0010011: funct3 001/instr[31:25]=0 -> SLLI; funct3 101/instr[31:25]=0 -> SRLI; funct3 101/instr[31:25]=0100000 -> SRAI.
REQ-005 SHALL set illegal=1 and shiftSel=00 for either opcode with funct3 001/101 and any other upper-7 value; all other instructions pass with shiftSel=00, illegal=0.
REQ-006 SHALL drive alu_b = {27'b0, instr[24:20]} for immediate shifts and the resolved rs2 operand for register shifts.
REQ-007 SHALL resolve each source operand as follows: index 0 -> 0; else EX/MEM match (we=1, rd equal, rd≠0) -> exmem_data; else MEM/WB match -> memwb_data; else register-file data.
REQ-008 SHALL give EX/MEM priority over MEM/WB when both match.
REQ-009 SHALL drive in_ready = !stall, combinationally; a transfer occurs on in_valid && in_ready.
REQ-010 SHALL capture decoded outputs on the edge after a transfer, a latency of 1 cycle; out_valid<=1.
REQ-011 SHALL hold every output unchanged while stall=1 and flush=0.
REQ-012 SHALL clear out_valid, shiftSel, and illegal on the next edge when flush=1, regardless of stall or in_valid; flush has top priority.
REQ-013 SHALL load out_valid<=0 when stall=0 and in_valid=0 (bubble); data outputs may retain prior values.
REQ-014 SHALL sample forwarding only at the capture edge; a held instruction is not re-resolved during a stall.

Reset
REQ-015 SHALL, while rst_n=0, asynchronously force out_valid=0, shiftSel=00, alu_a=0, alu_b=0, rd_out=0, and illegal=0, and drive in_ready=0.
REQ-016 SHALL discard any in-flight instruction on reset assertion; the first capture occurs on the first edge after deassertion.

Configuration
REQ-017 SHALL, with SHIFT_FWD_EN defined, implement REQ-007/008 forwarding.
REQ-018 SHALL, without SHIFT_FWD_EN, keep the forward ports but ignore them, using register-file data (index 0 still -> 0).

Structure
REQ-019 SHALL place the shiftSel encodings, the OP/OP-IMM opcodes, the funct3 values 001/101, and the funct7 values 0000000/0100000 in shared package shift_pkg.
REQ-020 SHALL implement decode (REQ-003..005) as the combinational sub-module shift_decode; forwarding and pipeline registers live in the top module.

Verification
REQ-021 SHALL verify SRAI: instr SRAI x5,x6,4, rs1_data=0x8000_0000 -> one cycle later out_valid=1, shiftSel=11, alu_a=0x8000_0000, alu_b=0x0000_0004, rd_out=5.
REQ-022 SHALL verify forward priority: SLL x3,x1,x2, exmem(we=1, rd=1, 0xAAAA_0000), memwb(we=1, rd=1, 0x1234), rs2 via memwb rd=2 data 7 -> alu_a=0xAAAA_0000, alu_b=7 (SHIFT_FWD_EN); without the macro -> rs1_data/rs2_data.
REQ-023 SHALL verify x0: SRL x4,x0,x0, exmem(we=1, rd=0, 0xFFFF_FFFF), rs1_data=5 -> alu_a=0, alu_b=0.
REQ-024 SHALL verify stall vs. flush: capture SLLI, then assert stall 3 cycles with a new instr presented -> outputs frozen and in_ready=0; then assert stall and flush together -> out_valid=0 on the next edge.
REQ-025 SHALL verify illegal: funct3 101, funct7 0000001, opcode 0110011 -> illegal=1, shiftSel=00, out_valid=1.
REQ-026 SHALL verify reset mid-operation: assert rst_n=0 between edges with out_valid=1 -> all outputs 0 immediately, no capture until after deassertion.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the ID/EX shift stage: shift selects, opcodes, funct fields,
// and the operand resolver used when SHIFT_FWD_EN enables forwarding.
package shift_pkg;
  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SLL  = 2'b01,
    SH_SRL  = 2'b10,
    SH_SRA  = 2'b11
  } shift_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // idx != 0 is checked first, so a matching rd is implicitly nonzero.
  function automatic logic [31:0] resolve_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)                  return 32'd0;
    else if (ex_we && (ex_rd == idx)) return ex_data;
    else if (wb_we && (wb_rd == idx)) return wb_data;
    else                              return rf_data;
  endfunction
endpackage

// File: rtl/shift_decode.sv
// Combinational shift decoder for OP / OP-IMM; flags malformed upper-7 fields.
module shift_decode
  import shift_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [1:0] sel,
  output logic       is_imm,
  output logic       illegal
);
  logic is_shift_op;

  assign is_shift_op = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
  assign is_imm      = (opcode == OPC_OP_IMM);

  always_comb begin
    sel     = SH_NONE;
    illegal = 1'b0;
    if (is_shift_op) begin
      case (funct3)
        F3_SLL: begin
          if (funct7 == F7_BASE) sel = SH_SLL;
          else                   illegal = 1'b1;
        end
        F3_SR: begin
          if (funct7 == F7_BASE)     sel = SH_SRL;
          else if (funct7 == F7_ALT) sel = SH_SRA;
          else                       illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register for RV32I shifts: decode, operand resolution, one-cycle capture.
// Build option: SHIFT_FWD_EN enables EX/MEM and MEM/WB forwarding of source operands.
module id_ex_shift_stage
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        memwb_we,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic        out_valid,
  output logic [1:0]  shiftSel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd_out,
  output logic        illegal
);
  logic [4:0]  rs1_idx, rs2_idx;
  logic [1:0]  dec_sel;
  logic        dec_imm, dec_illegal;
  logic [31:0] op_a, op_b, nxt_b;

  assign rs1_idx  = instr[19:15];
  assign rs2_idx  = instr[24:20];
  assign in_ready = rst_n && !stall;

  shift_decode u_dec (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .funct7  (instr[31:25]),
    .sel     (dec_sel),
    .is_imm  (dec_imm),
    .illegal (dec_illegal)
  );

`ifdef SHIFT_FWD_EN
  assign op_a = resolve_operand(rs1_idx, rs1_data, exmem_we, exmem_rd, exmem_data,
                                memwb_we, memwb_rd, memwb_data);
  assign op_b = resolve_operand(rs2_idx, rs2_data, exmem_we, exmem_rd, exmem_data,
                                memwb_we, memwb_rd, memwb_data);
`else
  // Forward ports stay on the interface so both builds share one wrapper.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data};
  assign op_a = (rs1_idx == 5'd0) ? 32'd0 : rs1_data;
  assign op_b = (rs2_idx == 5'd0) ? 32'd0 : rs2_data;
`endif

  assign nxt_b = dec_imm ? {27'd0, rs2_idx} : op_b;

  // Operands are sampled only on the capture edge, so a stalled entry is never re-resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      shiftSel  <= SH_NONE;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      rd_out    <= 5'd0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      shiftSel  <= SH_NONE;
      illegal   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        shiftSel <= dec_sel;
        alu_a    <= op_a;
        alu_b    <= nxt_b;
        rd_out   <= instr[11:7];
        illegal  <= dec_illegal;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Directed bench for id_ex_shift_stage; expectations queued at drive time, popped after capture.
module tb_id_ex_shift_stage;
  typedef struct packed {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, stall, flush;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, illegal;
  logic [1:0]  shiftSel;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  rd_out;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t held;

  always #5 clk = ~clk;

  id_ex_shift_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .shiftSel(shiftSel), .alu_a(alu_a), .alu_b(alu_b),
    .rd_out(rd_out), .illegal(illegal)
  );

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic exp_t mk(input logic v, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic il);
    exp_t e;
    e.vld = v; e.sel = s; e.a = a; e.b = b; e.rd = rd; e.ill = il;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e.vld});
    chk({tag, ".shiftSel"},  {30'd0, shiftSel},  {30'd0, e.sel});
    chk({tag, ".alu_a"},     alu_a, e.a);
    chk({tag, ".alu_b"},     alu_b, e.b);
    chk({tag, ".rd_out"},    {27'd0, rd_out},    {27'd0, e.rd});
    chk({tag, ".illegal"},   {31'd0, illegal},   {31'd0, e.ill});
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      held = e;
      chk_all(tag, e);
    end
  endtask

  task automatic clr_fwd();
    exmem_we = 0; exmem_rd = 0; exmem_data = 0;
    memwb_we = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  // Drive one transfer, let the capture edge pass, then compare.
  task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    instr = ins; rs1_data = a; rs2_data = b;
    in_valid = 1; stall = 0; flush = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
    pop_chk(tag);
    clr_fwd();
  endtask

  initial begin
    rst_n = 0; in_valid = 0; stall = 0; flush = 0;
    instr = 0; rs1_data = 0; rs2_data = 0;
    clr_fwd();
    #1;
    chk_all("reset", mk(0, 2'b00, 0, 0, 0, 0));
    chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
    #6 rst_n = 1;
    #1 chk("post_reset.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    send("srai", enc(7'b0100000, 5'd4, 5'd6, 3'b101, 5'd5, 7'b0010011),
         32'h8000_0000, 32'h0, mk(1, 2'b11, 32'h8000_0000, 32'h4, 5'd5, 0));

    exmem_we = 1; exmem_rd = 1; exmem_data = 32'hAAAA_0000;
    memwb_we = 1; memwb_rd = 1; memwb_data = 32'h0000_1234;
`ifdef SHIFT_FWD_EN
    send("fwd_prio", enc(7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011),
         32'h1111_1111, 32'h2222_2222, mk(1, 2'b01, 32'hAAAA_0000, 32'h2222_2222, 5'd3, 0));
`else
    send("fwd_prio", enc(7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011),
         32'h1111_1111, 32'h2222_2222, mk(1, 2'b01, 32'h1111_1111, 32'h2222_2222, 5'd3, 0));
`endif

    exmem_we = 1; exmem_rd = 1; exmem_data = 32'hAAAA_0000;
    memwb_we = 1; memwb_rd = 2; memwb_data = 32'h0000_0007;
`ifdef SHIFT_FWD_EN
    send("fwd_rs2", enc(7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011),
         32'h1111_1111, 32'h2222_2222, mk(1, 2'b01, 32'hAAAA_0000, 32'h7, 5'd3, 0));
`else
    send("fwd_rs2", enc(7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011),
         32'h1111_1111, 32'h2222_2222, mk(1, 2'b01, 32'h1111_1111, 32'h2222_2222, 5'd3, 0));
`endif

    exmem_we = 1; exmem_rd = 0; exmem_data = 32'hFFFF_FFFF;
    send("x0", enc(7'b0, 5'd0, 5'd0, 3'b101, 5'd4, 7'b0110011),
         32'h5, 32'h9, mk(1, 2'b10, 32'h0, 32'h0, 5'd4, 0));

    send("sra_reg", enc(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd6, 7'b0110011),
         32'hC000_0000, 32'h1F, mk(1, 2'b11, 32'hC000_0000, 32'h1F, 5'd6, 0));

    send("illegal", enc(7'b0000001, 5'd2, 5'd1, 3'b101, 5'd9, 7'b0110011),
         32'h3, 32'h4, mk(1, 2'b00, 32'h3, 32'h4, 5'd9, 1));

    send("illegal_imm", enc(7'b0100000, 5'd3, 5'd1, 3'b001, 5'd8, 7'b0010011),
         32'h3, 32'h4, mk(1, 2'b00, 32'h3, 32'h3, 5'd8, 1));

    send("add_pass", enc(7'b0, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0110011),
         32'h10, 32'h20, mk(1, 2'b00, 32'h10, 32'h20, 5'd10, 0));

    // Bubble: out_valid drops, data may linger.
    @(posedge clk); #1;
    chk("bubble.out_valid", {31'd0, out_valid}, 32'd0);

    send("slli", enc(7'b0, 5'd3, 5'd8, 3'b001, 5'd7, 7'b0010011),
         32'hF0F0_0001, 32'h0, mk(1, 2'b01, 32'hF0F0_0001, 32'h3, 5'd7, 0));

    instr = enc(7'b0100000, 5'd4, 5'd6, 3'b101, 5'd5, 7'b0010011);
    rs1_data = 32'h1234_5678; in_valid = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk_all("stall_hold", held);
      rs1_data = rs1_data + 32'd1;
    end
    flush = 1;
    @(posedge clk); #1;
    chk("stall_flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_flush.shiftSel", {30'd0, shiftSel}, 32'd0);
    chk("stall_flush.illegal", {31'd0, illegal}, 32'd0);

    // Flush beats an incoming transfer.
    stall = 0; flush = 1; in_valid = 1;
    @(posedge clk); #1;
    chk("flush_in.out_valid", {31'd0, out_valid}, 32'd0);
    flush = 0; in_valid = 0;

    send("pre_reset", enc(7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011),
         32'h55, 32'h2, mk(1, 2'b01, 32'h55, 32'h2, 5'd3, 0));
    instr = enc(7'b0, 5'd2, 5'd1, 3'b101, 5'd12, 7'b0110011);
    rs1_data = 32'h77; rs2_data = 32'h1; in_valid = 1;
    rst_n = 0;
    #1;
    chk_all("async_reset", mk(0, 2'b00, 0, 0, 0, 0));
    chk("async_reset.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk_all("reset_hold", mk(0, 2'b00, 0, 0, 0, 0));
    rst_n = 1;
    exp_q.push_back(mk(1, 2'b10, 32'h77, 32'h1, 5'd12, 0));
    @(posedge clk); #1;
    in_valid = 0;
    pop_chk("post_reset_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
